// File: rtl/dual_dac_sequencer_if.sv
// Configuration write bus for dual_dac_sequencer.
//   cfg_we    : write request, held by the requester until cfg_ack is seen
//   cfg_addr  : register address (0 CTRL, 1 STEP_A, 2 STEP_B, 3 BURST, 4 LEVEL)
//   cfg_wdata : write data
//   cfg_ack   : one-cycle write acknowledge from the sequencer
// master = board control / host side, slave = sequencer side.
interface dual_dac_sequencer_if;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_ack;

  modport master (output cfg_we, cfg_addr, cfg_wdata, input cfg_ack);
  modport slave  (input cfg_we, cfg_addr, cfg_wdata, output cfg_ack);
endinterface

// File: rtl/dual_dac_sequencer.sv
// Dual-channel DAC waveform sequencer.
// Holds per-channel waveform configuration (written over the cfg interface
// while idle) and runs an IDLE -> ARM -> RUN state machine. In RUN each
// channel's phase accumulator advances by its step every clock and a sample
// (constant / sawtooth / triangle / square) is registered onto the DAC bus.
// Outside RUN both buses sit at midscale.
// Ports:
//   clk       : system clock, all logic on posedge
//   nReset    : asynchronous active-low reset
//   cfg       : configuration write bus (slave side)
//   start     : level, begins a run from IDLE (ignored while busy)
//   stop      : level, aborts a run; wins over start
//   busy      : high in ARM and RUN
//   done      : one-cycle pulse when a burst completes
//   dac_a_d   : channel A sample, registered
//   dac_b_d   : channel B sample, registered
module dual_dac_sequencer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ACC_BITS  = 16,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      nReset,
  dual_dac_sequencer_if.slave       cfg,
  input  logic                      start,
  input  logic                      stop,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_BITS-1:0]      dac_a_d,
  output logic [DATA_BITS-1:0]      dac_b_d
);

  localparam logic [DATA_BITS-1:0] MIDSCALE = {1'b1, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  // configuration registers
  logic [1:0]           mode_a, mode_b;
  logic                 mirror_b;
  logic [ACC_BITS-1:0]  step_a, step_b;
  logic [CNT_BITS-1:0]  burst;
  logic [DATA_BITS-1:0] level_a, level_b;

  // run datapath
  logic [ACC_BITS-1:0]  acc_a, acc_b;
  logic [CNT_BITS-1:0]  cnt;
  logic [ACC_BITS:0]    sum_a;
  logic [ACC_BITS-1:0]  sum_b;
  logic                 burst_hit;

  // write handshake
  logic cfg_accept;
  logic ack_q;
  logic lock_q;

  // output-process results
  logic                 run_next;
  logic                 done_nxt;
  logic [DATA_BITS-1:0] samp_a, samp_b;

  // t is the top DATA_BITS+1 accumulator bits.
  function automatic logic [DATA_BITS-1:0] wave(
    input logic [1:0]           mode,
    input logic [DATA_BITS:0]   t,
    input logic [DATA_BITS-1:0] level
  );
    case (mode)
      2'd0:    wave = level;
      2'd1:    wave = t[DATA_BITS:1];
      2'd2:    wave = t[DATA_BITS] ? ~t[DATA_BITS-1:0] : t[DATA_BITS-1:0];
      default: wave = t[DATA_BITS] ? '1 : '0;
    endcase
  endfunction

  assign sum_a      = {1'b0, acc_a} + {1'b0, step_a};
  assign sum_b      = acc_b + step_b;
  // cnt is updated on the carry edge and compared here one cycle later, so
  // the final sample of the last period still reaches the outputs.
  assign burst_hit  = (burst != '0) && (cnt == burst);
  assign cfg_accept = (state == S_IDLE) && cfg.cfg_we && !lock_q;

  // state register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !stop)      state_nxt = S_ARM;
      S_ARM:  state_nxt = stop ? S_IDLE : S_RUN;
      S_RUN:  if (stop || burst_hit)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    busy     = (state != S_IDLE);
    run_next = (state == S_RUN) && (state_nxt == S_RUN);
    done_nxt = (state == S_RUN) && !stop && burst_hit;
    samp_a   = wave(mode_a, acc_a[ACC_BITS-1 -: DATA_BITS+1], level_a);
    samp_b   = mirror_b ? ~samp_a
                        : wave(mode_b, acc_b[ACC_BITS-1 -: DATA_BITS+1], level_b);
  end

  // configuration registers and write handshake
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      mode_a   <= '0;
      mode_b   <= '0;
      mirror_b <= 1'b0;
      step_a   <= '0;
      step_b   <= '0;
      burst    <= '0;
      level_a  <= MIDSCALE;
      level_b  <= MIDSCALE;
      ack_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      ack_q  <= cfg_accept;
      // a held request is acknowledged once; re-armed only after cfg_we drops
      lock_q <= cfg_accept | (lock_q & cfg.cfg_we);
      if (cfg_accept) begin
        case (cfg.cfg_addr)
          3'd0: begin
            mode_a   <= cfg.cfg_wdata[1:0];
            mode_b   <= cfg.cfg_wdata[3:2];
            mirror_b <= cfg.cfg_wdata[4];
          end
          3'd1: step_a <= ACC_BITS'(cfg.cfg_wdata);
          3'd2: step_b <= ACC_BITS'(cfg.cfg_wdata);
          3'd3: burst  <= CNT_BITS'(cfg.cfg_wdata);
          3'd4: begin
            level_a <= DATA_BITS'(cfg.cfg_wdata[7:0]);
            level_b <= DATA_BITS'(cfg.cfg_wdata[15:8]);
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg.cfg_ack = ack_q;

  // accumulators, burst counter and registered outputs
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      acc_a   <= '0;
      acc_b   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      dac_a_d <= MIDSCALE;
      dac_b_d <= MIDSCALE;
    end else begin
      done <= done_nxt;
      if (state == S_ARM) begin
        acc_a <= '0;
        acc_b <= '0;
        cnt   <= '0;
      end else if (state == S_RUN) begin
        acc_a <= sum_a[ACC_BITS-1:0];
        acc_b <= sum_b;
        if (sum_a[ACC_BITS] && (cnt != '1)) cnt <= cnt + CNT_BITS'(1);
      end
      if (run_next) begin
        dac_a_d <= samp_a;
        dac_b_d <= samp_b;
      end else begin
        dac_a_d <= MIDSCALE;
        dac_b_d <= MIDSCALE;
      end
    end
  end

endmodule

// File: tb/tb_dual_dac_sequencer.sv
module tb_dual_dac_sequencer;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy, done;
  logic [7:0] dac_a_d, dac_b_d;

  int n_checks = 0;
  int n_pass   = 0;

  dual_dac_sequencer_if cfg_bus ();

  dual_dac_sequencer #(
    .DATA_BITS(8),
    .ACC_BITS(16),
    .CNT_BITS(16)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .cfg(cfg_bus.slave),
    .start(start),
    .stop(stop),
    .busy(busy),
    .done(done),
    .dac_a_d(dac_a_d),
    .dac_b_d(dac_b_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference waveform from the accumulator value (16-bit acc, 8-bit DAC).
  function automatic int wave_ref(input int mode, input int acc, input int level);
    int t;
    case (mode)
      0: return level;
      1: return acc / 256;
      2: begin
        t = acc / 128;
        return (t < 256) ? t : 511 - t;
      end
      default: return (acc >= 32768) ? 255 : 0;
    endcase
  endfunction

  // Write while IDLE; holds cfg_we one extra cycle to confirm a single ack.
  task automatic cfg_write(input int addr, input int data);
    cfg_bus.cfg_addr  = 3'(addr);
    cfg_bus.cfg_wdata = 16'(data);
    cfg_bus.cfg_we    = 1'b1;
    @(negedge clk);
    check("cfg_ack", cfg_bus.cfg_ack, 1);
    @(negedge clk);
    check("cfg_ack_once", cfg_bus.cfg_ack, 0);
    cfg_bus.cfg_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_check(input int ma, input int mb, input int mir,
                           input int sa, input int sb, input int la,
                           input int lb, input int burst, input int ncont);
    int nsamp, ea, eb;
    cfg_write(0, ma | (mb << 2) | (mir << 4));
    cfg_write(1, sa);
    cfg_write(2, sb);
    cfg_write(3, burst);
    cfg_write(4, la | (lb << 8));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_arm", busy, 1);
    check("dac_arm", dac_a_d, 'h80);
    @(negedge clk);
    check("busy_run", busy, 1);
    check("dac_pre", dac_a_d, 'h80);
    // burst ends once floor(m*step/2^16) reaches BURST
    nsamp = (burst != 0) ? (burst * 65536 + sa - 1) / sa : ncont;
    for (int k = 0; k < nsamp; k++) begin
      @(negedge clk);
      ea = wave_ref(ma, (k * sa) % 65536, la);
      eb = (mir != 0) ? 255 - ea : wave_ref(mb, (k * sb) % 65536, lb);
      check("dac_a", dac_a_d, ea);
      check("dac_b", dac_b_d, eb);
      check("done_early", done, 0);
    end
    if (burst != 0) begin
      @(negedge clk);
      check("done_pulse", done, 1);
      check("busy_end", busy, 0);
      check("dac_a_end", dac_a_d, 'h80);
      check("dac_b_end", dac_b_d, 'h80);
      @(negedge clk);
      check("done_once", done, 0);
    end else begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("busy_stop", busy, 0);
      check("done_stop", done, 0);
      check("dac_a_stop", dac_a_d, 'h80);
      check("dac_b_stop", dac_b_d, 'h80);
    end
  endtask

  initial begin
    int b;
    cfg_bus.cfg_we    = 1'b0;
    cfg_bus.cfg_addr  = '0;
    cfg_bus.cfg_wdata = '0;

    #12;
    check("rst_dac_a", dac_a_d, 'h80);
    check("rst_dac_b", dac_b_d, 'h80);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack", cfg_bus.cfg_ack, 0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    // sawtooth, two-period burst
    run_check(1, 0, 0, 'h100, 0, 'h80, 'h80, 2, 0);
    // square with mirrored B, continuous
    run_check(3, 0, 1, 'h8000, 0, 'h80, 'h80, 0, 20);
    // triangle over more than one period
    run_check(2, 0, 0, 'h200, 0, 'h80, 'h80, 0, 300);

    // write held during RUN stalls until IDLE
    cfg_write(0, 0);
    cfg_write(1, 0);
    cfg_write(3, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cfg_bus.cfg_addr  = 3'd4;
    cfg_bus.cfg_wdata = 16'h1234;
    cfg_bus.cfg_we    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ack_stall", cfg_bus.cfg_ack, 0);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("ack_stop_edge", cfg_bus.cfg_ack, 0);
    @(negedge clk);
    check("ack_after_idle", cfg_bus.cfg_ack, 1);
    cfg_bus.cfg_we = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("level_a", dac_a_d, 'h34);
    check("level_b", dac_b_d, 'h12);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("start_stop_busy", busy, 0);
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      b = $urandom_range(0, 3);
      run_check($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range('h400, 'hFFFF), $urandom_range(0, 'hFFFF),
                $urandom_range(0, 255), $urandom_range(0, 255),
                b, $urandom_range(20, 60));
    end

    // async reset mid-run restores outputs and configuration
    cfg_write(0, 'h1D);
    cfg_write(1, 'h0300);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    nReset = 1'b0;
    #1;
    check("mid_rst_dac_a", dac_a_d, 'h80);
    check("mid_rst_dac_b", dac_b_d, 'h80);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_busy", busy, 1);
      check("post_rst_a", dac_a_d, 'h80);
      check("post_rst_b", dac_b_d, 'h80);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("post_rst_stop", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
